// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM4Kx4 data port.
// Each access holds ram_cs for ACC_CYC cycles, then pulses done to the winner.
module ram_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 4,
    parameter int ACC_CYC = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        fsm_state
);

    // Handshake: a requester holds req high with stable addr/we/wdata until its
    // done pulse; requests are only sampled in IDLE and an access never aborts
    // except by reset.

    localparam int CYC = (ACC_CYC < 1) ? 1 : ACC_CYC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_d;
    logic              rr_ptr, rr_ptr_d;
    logic [3:0]        cnt, cnt_d;
    logic              gnt0_d, gnt1_d, done0_d, done1_d;
    logic              ram_cs_d, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d, rdata_d;
    logic              win1;

    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cnt       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rdata     <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            cnt       <= cnt_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            ram_cs    <= ram_cs_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            rdata     <= rdata_d;
        end
    end

    // Port 1 wins when it is the only requester or when both ask and it is its turn.
    assign win1 = req1 & (~req0 | rr_ptr);

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        cnt_d       = cnt;
        gnt0_d      = gnt0;
        gnt1_d      = gnt1;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        ram_cs_d    = ram_cs;
        ram_we_d    = ram_we;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        rdata_d     = rdata;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    ram_addr_d  = win1 ? addr1  : addr0;
                    ram_we_d    = win1 ? we1    : we0;
                    ram_wdata_d = win1 ? wdata1 : wdata0;
                    gnt0_d      = ~win1;
                    gnt1_d      = win1;
                    ram_cs_d    = 1'b1;
                    cnt_d       = 4'(CYC - 1);
                    rr_ptr_d    = ~win1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    // The grant flags still identify the owner on this last edge.
                    done0_d  = gnt0;
                    done1_d  = gnt1;
                    gnt0_d   = 1'b0;
                    gnt1_d   = 1'b0;
                    ram_cs_d = 1'b0;
                    ram_we_d = 1'b0;
                    if (!ram_we) rdata_d = ram_rdata;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 4Kx4 RAM behind it.
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [3:0]  wdata0, wdata1;
    logic        gnt0, done0, gnt1, done1;
    logic [3:0]  rdata;
    logic [11:0] ram_addr;
    logic        ram_cs, ram_we;
    logic [3:0]  ram_wdata, ram_rdata;
    logic [1:0]  fsm_state;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] mem [0:4095];

    always #5 clock = ~clock;

    ram_port_arbiter #(.ADDR_W(12), .DATA_W(4), .ACC_CYC(2)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .fsm_state(fsm_state)
    );

    // RAM model: synchronous write, asynchronous read.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clock) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Grants and done pulses must never overlap.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            chk("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
            chk("done_overlap", 32'(done0 & done1), 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
        mem[12'hFFF] = 4'h7;
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h000; wdata0 = 4'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h000; wdata1 = 4'h0;

        // T1 reset with both requests high
        tick(); tick();
        chk("t1_gnt0", gnt0, 1'b0);
        chk("t1_gnt1", gnt1, 1'b0);
        chk("t1_done", {done0, done1}, 2'b00);
        chk("t1_cs_we", {ram_cs, ram_we}, 2'b00);
        chk("t1_rdata", rdata, 4'h0);
        chk("t1_state", fsm_state, 2'd0);
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("t1_idle", {fsm_state, ram_cs}, 3'b000);

        // T2 write 0xA to 0x123 then read it back
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h123; wdata0 = 4'hA;
        tick();
        chk("t2w_gnt0", gnt0, 1'b1);
        chk("t2w_cs_we", {ram_cs, ram_we}, 2'b11);
        chk("t2w_addr", ram_addr, 12'h123);
        chk("t2w_wdata", ram_wdata, 4'hA);
        tick();
        chk("t2w_cs2", {ram_cs, ram_we, done0}, 3'b110);
        tick();
        chk("t2w_done", {done0, gnt0, ram_cs, ram_we}, 4'b1000);
        chk("t2w_rdata_kept", rdata, 4'h0);
        req0 = 1'b0;
        tick();
        chk("t2w_done_end", done0, 1'b0);
        req0 = 1'b1; we0 = 1'b0;
        tick();
        chk("t2r_cs_we", {gnt0, ram_cs, ram_we}, 3'b110);
        tick();
        chk("t2r_cs2", {ram_cs, done0}, 2'b10);
        tick();
        chk("t2r_done", {done0, ram_cs}, 2'b10);
        chk("t2r_rdata", rdata, 4'hA);
        req0 = 1'b0;
        tick();
        chk("t2r_hold", {done0, rdata}, 5'h0A);

        // T3 contention after reset: grants 0,1,0,1 with a 4-cycle period
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h111;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h222;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("t3_gnt", {gnt0, gnt1}, (g % 2 == 0) ? 2'b10 : 2'b01);
            chk("t3_addr", ram_addr, (g % 2 == 0) ? 12'h111 : 12'h222);
            tick();
            tick();
            chk("t3_done", {done0, done1}, (g % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            chk("t3_idle", {gnt0, gnt1, done0, done1}, 4'b0000);
        end
        req0 = 1'b0; req1 = 1'b0;

        // T4 address latched despite addr1 change during ACCESS
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'hFFF;
        tick();
        chk("t4_gnt1", gnt1, 1'b1);
        chk("t4_addr_a", ram_addr, 12'hFFF);
        addr1 = 12'h000;
        tick();
        chk("t4_addr_b", ram_addr, 12'hFFF);
        tick();
        chk("t4_done1", done1, 1'b1);
        chk("t4_rdata", rdata, 4'h7);
        req1 = 1'b0;
        tick();

        // T5 req0 dropped one cycle after grant
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123;
        tick();
        chk("t5_gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        tick();
        tick();
        chk("t5_done0", done0, 1'b1);
        chk("t5_rdata", rdata, 4'hA);
        tick();
        chk("t5_done_once", done0, 1'b0);
        tick();
        chk("t5_no_regrant", {gnt0, ram_cs}, 2'b00);
        tick();
        chk("t5_no_done", done0, 1'b0);

        // T6 reset during second ACCESS cycle of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h010; wdata0 = 4'h5;
        tick();
        chk("t6_write", {ram_cs, ram_we}, 2'b11);
        tick();
        chk("t6_second", {ram_cs, ram_we, fsm_state}, 4'b1101);
        reset = 1'b1;
        tick();
        chk("t6_abort", {ram_cs, ram_we, gnt0, done0}, 4'b0000);
        chk("t6_state", fsm_state, 2'd0);
        chk("t6_rdata", rdata, 4'h0);
        reset = 1'b0; req0 = 1'b0;
        tick();
        chk("t6_no_done", {done0, fsm_state}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
